frame_window_select: RTL and testbench

Multi-channel, runtime-configurable successor to the fixed single-channel frame window selector in the interferometer acquisition path.
- Counts valid samples into frames of FRAME_WIDTH.
- Forwards only samples inside a programmable window [start, start+len) for all channels in lockstep.
- Marks window start/end and reports resync and configuration errors.
- Sits between the ADC/demod sample stream and the phase-processing chain.

---
 rtl/frame_sel_pkg.sv | 18 +
 rtl/frame_index_counter.sv | 43 ++++
 rtl/frame_window_select.sv | 94 +++++++++
 tb/tb_frame_window_select.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/frame_sel_pkg.sv
// frame_sel_pkg: shared constants, index-width helper and window config record
package frame_sel_pkg;
   localparam int DEFAULT_FRAME_WIDTH = 256;
   localparam int DEFAULT_START = 26;
   localparam int DEFAULT_LEN = 204;
   localparam int CFG_START_W = 16;
   localparam int CFG_LEN_W = 17;

   function automatic int cnt_width(input int frame_width);
      return (frame_width <= 2) ? 1 : $clog2(frame_width);
   endfunction

   // sized for the largest legal frame so one type serves every instance
   typedef struct packed {
      logic [CFG_START_W-1:0] start;
      logic [CFG_LEN_W-1:0]   len;
   } win_cfg_t;
endpackage

// File: rtl/frame_index_counter.sv
// frame_index_counter: per-sample frame index, wrap/frame_sync handling,
// first-frame flag, resync pulse and frame boundary strobe
module frame_index_counter #(
   parameter int FRAME_WIDTH = 256,
   parameter int CNT_WIDTH = 8
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_valid,
   input  logic                 i_sync,
   output logic [CNT_WIDTH-1:0] o_index,
   output logic                 o_first,
   output logic                 o_bound,
   output logic                 o_resync
);
   localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(FRAME_WIDTH - 1);

   logic [CNT_WIDTH-1:0] r_cnt;
   logic                 r_first;
   logic                 w_resync;
   logic                 w_close;

   // r_cnt is the index the next valid sample would get without a sync
   assign w_resync = i_valid & i_sync & (r_cnt != '0);
   assign o_index  = (i_valid & i_sync) ? '0 : r_cnt;
   assign o_first  = r_first & ~w_resync;
   assign o_bound  = i_valid & (o_index == '0);
   assign w_close  = (o_index == LAST) | w_resync;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_cnt    <= '0;
         r_first  <= 1'b1;
         o_resync <= 1'b0;
      end else begin
         o_resync <= w_resync;
         if (i_valid) begin
            r_cnt <= (o_index == LAST) ? '0 : o_index + CNT_WIDTH'(1);
            if (w_close) r_first <= 1'b0;
         end
      end
   end
endmodule

// File: rtl/frame_window_select.sv
// frame_window_select: forwards multi-channel samples whose frame index lies in a
// runtime-programmable window, with sof/eof marks, resync and config error flags
module frame_window_select
   import frame_sel_pkg::*;
#(
   parameter int DATA_WIDTH       = 32,
   parameter int CHANNELS         = 2,
   parameter int FRAME_WIDTH      = DEFAULT_FRAME_WIDTH,
   parameter int DEFAULT_START    = frame_sel_pkg::DEFAULT_START,
   parameter int DEFAULT_LEN      = frame_sel_pkg::DEFAULT_LEN,
   parameter bit FIRST_FRAME_FULL = 1'b1,
   localparam int CNT_WIDTH       = cnt_width(FRAME_WIDTH)
) (
   input  logic                           i_clk,
   input  logic                           i_rst_n,
   input  logic [CNT_WIDTH-1:0]           i_cfg_start,
   input  logic [CNT_WIDTH:0]             i_cfg_len,
   input  logic                           i_cfg_load,
   input  logic                           i_frame_sync,
   input  logic [CHANNELS*DATA_WIDTH-1:0] i_data_in,
   input  logic                           i_data_in_valid,
   output logic [CHANNELS*DATA_WIDTH-1:0] o_data_out,
   output logic                           o_data_out_valid,
   output logic                           o_data_out_sof,
   output logic                           o_data_out_eof,
   output logic                           o_resync,
   output logic                           o_cfg_err
);
   localparam int XW = CNT_WIDTH + 2;
   localparam win_cfg_t RESET_CFG = '{start: CFG_START_W'(DEFAULT_START), len: CFG_LEN_W'(DEFAULT_LEN)};

   win_cfg_t             r_active;
   win_cfg_t             r_shadow;
   logic                 r_shv;
   win_cfg_t             w_cfg;
   logic [CNT_WIDTH-1:0] w_idx;
   logic                 w_first;
   logic                 w_bound;
   logic [17:0]          w_i;
   logic [17:0]          w_lo;
   logic [17:0]          w_hi;
   logic                 w_in;
   logic                 w_legal;

   frame_index_counter #(.FRAME_WIDTH(FRAME_WIDTH), .CNT_WIDTH(CNT_WIDTH)) u_cnt (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .i_valid  (i_data_in_valid),
      .i_sync   (i_frame_sync),
      .o_index  (w_idx),
      .o_first  (w_first),
      .o_bound  (w_bound),
      .o_resync (o_resync)
   );

   // a pending shadow already governs the boundary sample that installs it
   assign w_cfg   = (w_bound & r_shv) ? r_shadow : r_active;
   assign w_i     = 18'(w_idx);
   assign w_hi    = 18'(w_cfg.start) + 18'(w_cfg.len);
   assign w_lo    = (FIRST_FRAME_FULL && w_first) ? '0 : 18'(w_cfg.start);
   assign w_in    = i_data_in_valid & (w_i >= w_lo) & (w_i < w_hi);
   assign w_legal = (i_cfg_len != '0) &
                    ((XW'(i_cfg_start) + XW'(i_cfg_len)) <= XW'(FRAME_WIDTH));

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_active         <= RESET_CFG;
         r_shadow         <= '0;
         r_shv            <= 1'b0;
         o_data_out       <= '0;
         o_data_out_valid <= 1'b0;
         o_data_out_sof   <= 1'b0;
         o_data_out_eof   <= 1'b0;
         o_cfg_err        <= 1'b0;
      end else begin
         o_data_out_valid <= w_in;
         o_data_out_sof   <= w_in & (w_i == w_lo);
         o_data_out_eof   <= w_in & (w_i == w_hi - 18'd1);
         if (w_in) o_data_out <= i_data_in;
         if (w_bound & r_shv) begin
            r_active <= r_shadow;
            r_shv    <= 1'b0;
         end
         // a load on the boundary cycle lands after the transfer, so it waits a frame
         if (i_cfg_load) begin
            o_cfg_err <= ~w_legal;
            if (w_legal) begin
               r_shadow <= '{start: CFG_START_W'(i_cfg_start), len: CFG_LEN_W'(i_cfg_len)};
               r_shv    <= 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_frame_window_select.sv
// tb_frame_window_select: directed checks of windowing, reconfiguration, resync
// and reset on a 2x32 and a 4x16 instance driven in lockstep
module tb_frame_window_select;
   typedef struct {
      int start;
      int len;
      bit err;
   } cfg_vec_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  cfg_start = '0;
   logic [8:0]  cfg_len = '0;
   logic        cfg_load = 1'b0;
   logic        sync = 1'b0;
   logic        valid = 1'b0;
   logic [63:0] din = '0;
   logic [63:0] a_do, b_do, last_d;
   logic        a_v, a_sof, a_eof, a_rs, a_err;
   logic        b_v, b_sof, b_eof, b_rs, b_err;
   int          checks = 0;
   int          failures = 0;
   int          fc = 0;
   cfg_vec_t    tbl[7];

   always #5 clk = ~clk;

   frame_window_select #(.DATA_WIDTH(32), .CHANNELS(2)) u_a (
      .i_clk(clk), .i_rst_n(rst_n), .i_cfg_start(cfg_start), .i_cfg_len(cfg_len),
      .i_cfg_load(cfg_load), .i_frame_sync(sync), .i_data_in(din), .i_data_in_valid(valid),
      .o_data_out(a_do), .o_data_out_valid(a_v), .o_data_out_sof(a_sof),
      .o_data_out_eof(a_eof), .o_resync(a_rs), .o_cfg_err(a_err)
   );

   frame_window_select #(.DATA_WIDTH(16), .CHANNELS(4)) u_b (
      .i_clk(clk), .i_rst_n(rst_n), .i_cfg_start(cfg_start), .i_cfg_len(cfg_len),
      .i_cfg_load(cfg_load), .i_frame_sync(sync), .i_data_in(din), .i_data_in_valid(valid),
      .o_data_out(b_do), .o_data_out_valid(b_v), .o_data_out_sof(b_sof),
      .o_data_out_eof(b_eof), .o_resync(b_rs), .o_cfg_err(b_err)
   );

   task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", n, act, exp);
      end
   endtask

   task automatic out(input bit ev, input logic [63:0] ed, input bit es, input bit ee, input bit er);
      if (ev) last_d = ed;
      chk("a_valid", a_v, ev);   chk("b_valid", b_v, ev);
      chk("a_data", a_do, last_d); chk("b_data", b_do, last_d);
      chk("a_sof", a_sof, ev & es); chk("b_sof", b_sof, ev & es);
      chk("a_eof", a_eof, ev & ee); chk("b_eof", b_eof, ev & ee);
      chk("a_resync", a_rs, er);  chk("b_resync", b_rs, er);
   endtask

   task automatic err(input bit e);
      chk("a_cfg_err", a_err, e);
      chk("b_cfg_err", b_err, e);
   endtask

   task automatic tick(input bit v, input bit s, input logic [63:0] d);
      valid = v; sync = s; din = d;
      @(posedge clk); #1;
      valid = 1'b0; sync = 1'b0; cfg_load = 1'b0;
   endtask

   // four 16-bit lanes, each a distinct ramp tagged by lane number
   function automatic logic [63:0] mk(input int f, input int i);
      logic [63:0] r;
      for (int k = 0; k < 4; k++) r[16*k +: 16] = 16'((k << 12) | ((f * 256 + i) & 'hfff));
      return r;
   endfunction

   task automatic do_reset();
      rst_n = 1'b0;
      tick(1'b0, 1'b0, '0);
      tick(1'b0, 1'b0, '0);
      rst_n = 1'b1;
      last_d = '0;
   endtask

   task automatic run_frame(input int lo, input int hi, input bit rnd, input bit s0, input bit rs0,
                            input int stop, input int ld_at, input int ld_s, input int ld_l);
      for (int i = 0; i < stop; i++) begin
         if (rnd) while ($urandom_range(1, 0) == 1) begin
            tick(1'b0, 1'b0, '0);
            out(1'b0, '0, 1'b0, 1'b0, 1'b0);
         end
         if (i == ld_at) begin
            cfg_start = 8'(ld_s); cfg_len = 9'(ld_l); cfg_load = 1'b1;
         end
         tick(1'b1, s0 && i == 0, mk(fc, i));
         out(i >= lo && i < hi, mk(fc, i), i == lo, i == hi - 1, rs0 && i == 0);
         if (i == ld_at) err(1'b0);
      end
      fc++;
   endtask

   initial begin
      tbl = '{'{255, 1, 1'b0}, '{200, 100, 1'b1}, '{0, 0, 1'b1}, '{100, 157, 1'b1},
              '{255, 2, 1'b1}, '{10, 5, 1'b0}, '{11, 250, 1'b1}};
      last_d = '0;
      do_reset();
      out(1'b0, '0, 1'b0, 1'b0, 1'b0);
      err(1'b0);
      // defaults, continuous valid
      run_frame(0, 230, 0, 0, 0, 256, -1, 0, 0);
      run_frame(26, 230, 0, 0, 0, 256, -1, 0, 0);
      run_frame(26, 230, 0, 0, 0, 256, -1, 0, 0);
      // defaults, gappy valid
      do_reset();
      run_frame(0, 230, 1, 0, 0, 256, -1, 0, 0);
      run_frame(26, 230, 1, 0, 0, 256, -1, 0, 0);
      run_frame(26, 230, 1, 0, 0, 256, -1, 0, 0);
      // full-frame window loaded mid-frame
      do_reset();
      run_frame(0, 230, 0, 0, 0, 256, -1, 0, 0);
      run_frame(26, 230, 0, 0, 0, 256, 100, 0, 256);
      run_frame(0, 256, 0, 0, 0, 256, -1, 0, 0);
      // legality table, loads on idle cycles, last legal wins
      foreach (tbl[n]) begin
         cfg_start = 8'(tbl[n].start); cfg_len = 9'(tbl[n].len); cfg_load = 1'b1;
         tick(1'b0, 1'b0, '0);
         err(tbl[n].err);
         out(1'b0, '0, 1'b0, 1'b0, 1'b0);
      end
      run_frame(10, 15, 0, 0, 0, 256, -1, 0, 0);
      err(1'b1);
      // load on the boundary sample applies one frame later
      run_frame(10, 15, 0, 0, 0, 256, 0, 26, 204);
      run_frame(26, 230, 0, 0, 0, 256, 50, 5, 1);
      run_frame(5, 6, 0, 0, 0, 256, 50, 26, 204);
      // resync truncates an open window
      run_frame(26, 230, 0, 0, 0, 100, -1, 0, 0);
      run_frame(26, 230, 0, 1, 1, 256, -1, 0, 0);
      run_frame(26, 230, 0, 1, 0, 256, -1, 0, 0);
      // reset inside an open window
      run_frame(26, 230, 0, 0, 0, 100, -1, 0, 0);
      rst_n = 1'b0;
      tick(1'b1, 1'b0, mk(fc, 100));
      last_d = '0;
      out(1'b0, '0, 1'b0, 1'b0, 1'b0);
      err(1'b0);
      rst_n = 1'b1;
      fc++;
      run_frame(0, 230, 0, 0, 0, 256, -1, 0, 0);
      run_frame(26, 230, 0, 0, 0, 256, -1, 0, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
